// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants, FSM state type and digit legality helper for the
// digit-serial BCD adder.
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned ADJ     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Codes 1010..1111 are not decimal digits.
    function automatic logic is_illegal_digit(input logic [BCD_W-1:0] d);
        return d[3] & (d[2] | d[1]);
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle for bcd_serial_adder; master issues operations,
// slave (the adder) returns results.
interface bcd_serial_adder_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  c_out;
    logic                  out_of_range;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, out_of_range
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, out_of_range
    );
endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with optional nines-complement of b (for
// ten's-complement subtraction) and +6 decimal adjust.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    logic [BCD_W-1:0] b_eff;
    logic [BCD_W:0]   raw;
    logic [BCD_W:0]   adj;

    always_comb begin
        b_eff = sub ? (BCD_W'(BCD_MAX) - b) : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {{BCD_W{1'b0}}, cin};
        adj   = raw + (BCD_W+1)'(ADJ);
        if (raw > (BCD_W+1)'(BCD_MAX)) begin
            s    = adj[BCD_W-1:0];
            cout = 1'b1;
        end else begin
            s    = raw[BCD_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder/subtractor: one digit per clock, LSD first,
// with a registered decimal carry and start/busy/done framing.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input logic              clk,
    input logic              reset,
    bcd_serial_adder_if.slave bus
);

    localparam int unsigned W    = BCD_W * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic              cout_q, cout_d;
    logic              oor_q, oor_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;

    logic [BCD_W-1:0]  a_dig, b_dig, s_dig;
    logic              dig_cout;
    logic              any_illegal;
    logic              accept;

    // Operand check is done on the values being latched so an illegal request
    // reaches DONE one cycle after start.
    always_comb begin
        any_illegal = 1'b0;
        a_dig       = '0;
        b_dig       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            any_illegal = any_illegal
                        | is_illegal_digit(bus.a[i*BCD_W +: BCD_W])
                        | is_illegal_digit(bus.b[i*BCD_W +: BCD_W]);
            if (idx_q == IdxW'(i)) begin
                a_dig = a_q[i*BCD_W +: BCD_W];
                b_dig = b_q[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_digit_add u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .sub  (sub_q),
        .s    (s_dig),
        .cout (dig_cout)
    );

    assign accept = bus.start && (state_q != ADD);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        oor_d   = oor_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;

        if (accept) begin
            a_d    = bus.a;
            b_d    = bus.b;
            sub_d  = bus.sub;
            sum_d  = '0;
            idx_d  = '0;
            cout_d = 1'b0;
            if (any_illegal) begin
                state_d = DONE;
                oor_d   = 1'b1;
                carry_d = 1'b0;
            end else begin
                state_d = ADD;
                oor_d   = 1'b0;
                carry_d = bus.sub;
            end
        end else begin
            case (state_q)
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IdxW'(i)) sum_d[i*BCD_W +: BCD_W] = s_dig;
                    end
                    carry_d = dig_cout;
                    if (idx_q == IdxW'(DIGITS - 1)) begin
                        cout_d  = dig_cout;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            oor_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            oor_q   <= oor_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.busy         = (state_q == ADD);
    assign bus.done         = (state_q == DONE);
    assign bus.sum          = sum_q;
    assign bus.c_out        = cout_q;
    assign bus.out_of_range = oor_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4): stimulus pushes the
// hand-computed result, a negedge monitor pops and compares on done.
module tb_bcd_serial_adder;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        oor;
    } exp_t;

    exp_t exp_q[$];

    bcd_serial_adder_if #(.DIGITS(4)) bif ();

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bif.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = exp_q.pop_front();
                check("sum", {16'h0, bif.sum}, {16'h0, e.sum});
                check("c_out", {31'h0, bif.c_out}, {31'h0, e.c});
                check("out_of_range", {31'h0, bif.out_of_range}, {31'h0, e.oor});
            end
        end
    end

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input int elat, input int ebusy, input bit b2b, input bit poke);
        int   lat  = 0;
        int   bc   = 0;
        bit   seen = 1'b0;
        exp_t e;
        if (!b2b) @(negedge clk);
        e.sum = es;
        e.c   = ec;
        e.oor = eo;
        exp_q.push_back(e);
        bif.a     = av;
        bif.b     = bv;
        bif.sub   = sv;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (poke && c == 2) begin
                bif.start = 1'b1;
                bif.a     = 16'h9999;
                bif.b     = 16'h9999;
                bif.sub   = 1'b1;
            end else if (poke && c == 3) begin
                bif.start = 1'b0;
            end
            if (bif.busy) bc++;
            if (bif.done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("latency", lat, elat);
        check("busy_cycles", bc, ebusy);
    endtask

    initial begin
        reset     = 1'b1;
        bif.start = 1'b0;
        bif.sub   = 1'b0;
        bif.a     = '0;
        bif.b     = '0;
        #12;
        check("rst_busy", {31'h0, bif.busy}, 0);
        check("rst_done", {31'h0, bif.done}, 0);
        check("rst_sum", {16'h0, bif.sum}, 0);
        check("rst_c_out", {31'h0, bif.c_out}, 0);
        check("rst_oor", {31'h0, bif.out_of_range}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
        // Start pulsed mid-ADD with other operands must not disturb the result.
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 5, 4, 1'b0, 1'b1);
        // Second request issued in the DONE cycle of the first.
        run_op(16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0);
        run_op(16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0, 5, 4, 1'b1, 1'b0);

        // Asynchronous reset after two digits have been written.
        @(negedge clk);
        bif.a     = 16'h1111;
        bif.b     = 16'h2222;
        bif.sub   = 1'b0;
        bif.start = 1'b1;
        @(posedge clk);
        #1 bif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'h0, bif.busy}, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, bif.busy}, 0);
        check("mid_rst_done", {31'h0, bif.done}, 0);
        check("mid_rst_sum", {16'h0, bif.sum}, 0);
        check("mid_rst_c_out", {31'h0, bif.c_out}, 0);
        check("mid_rst_oor", {31'h0, bif.out_of_range}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
